// File: rtl/l2_req_arbiter.sv
// L2 request arbiter: picks one of snoop / L1D / L1I, drives a single command
// into the cache datapath and returns a one-cycle completion response.
// Snoop always wins. L1D and L1I alternate round-robin between themselves.
// Optional macro L2_ARB_STATS_EN adds saturating rd/wr/hit completion counters.
module l2_req_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l1d_req,
  input  logic [3:0]        l1d_cmd,
  input  logic [ADDR_W-1:0] l1d_addr,
  output logic              l1d_gnt,
  input  logic              l1i_req,
  input  logic [ADDR_W-1:0] l1i_addr,
  output logic              l1i_gnt,
  input  logic              snp_req,
  input  logic [3:0]        snp_cmd,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              snp_gnt,
  output logic              c_valid,
  output logic [3:0]        c_cmd,
  output logic [ADDR_W-1:0] c_addr,
  output logic [1:0]        c_src,
  input  logic              c_done,
  input  logic              c_hit,
  output logic              rsp_valid,
  output logic [1:0]        rsp_src,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic              busy
`ifdef L2_ARB_STATS_EN
  ,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output logic [31:0]       hit_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SRC_L1D = 2'd0;
  localparam logic [1:0] SRC_L1I = 2'd1;
  localparam logic [1:0] SRC_SNP = 2'd2;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              rr_l1i;     // 1: L1I wins the next L1D/L1I tie
  logic [3:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        src_q;
  logic              legal_q;
  logic              hit_q;
  logic              err_q;
  logic [15:0]       wait_cnt;

  logic              any_req;
  logic [1:0]        win_src;
  logic [3:0]        win_cmd;
  logic [ADDR_W-1:0] win_addr;
  logic              win_legal;

  // Fixed snoop priority, round-robin tie-break between the two L1 ports.
  always_comb begin
    any_req  = snp_req | l1d_req | l1i_req;
    win_src  = SRC_L1D;
    win_cmd  = l1d_cmd;
    win_addr = l1d_addr;
    if (snp_req) begin
      win_src  = SRC_SNP;
      win_cmd  = snp_cmd;
      win_addr = snp_addr;
    end else if (l1i_req && (!l1d_req || rr_l1i)) begin
      win_src  = SRC_L1I;
      win_cmd  = 4'd2;
      win_addr = l1i_addr;
    end
  end

  // Commands each port may legally issue; anything else is granted and errored.
  always_comb begin
    win_legal = 1'b0;
    case (win_src)
      SRC_L1D: win_legal = (win_cmd == 4'd0) || (win_cmd == 4'd1) ||
                           (win_cmd == 4'd8) || (win_cmd == 4'd9);
      SRC_L1I: win_legal = 1'b1;
      default: win_legal = (win_cmd >= 4'd3) && (win_cmd <= 4'd6);
    endcase
  end

  // Transaction FSM: latch winner, issue, wait for done or timeout, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_l1i   <= 1'b0;
      cmd_q    <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      legal_q  <= 1'b0;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          cmd_q   <= win_cmd;
          addr_q  <= win_addr;
          src_q   <= win_src;
          legal_q <= win_legal;
          hit_q   <= 1'b0;
          err_q   <= 1'b0;
          if (win_src == SRC_L1D) rr_l1i <= 1'b1;
          if (win_src == SRC_L1I) rr_l1i <= 1'b0;
          state   <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!legal_q) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else if (c_done) begin
            hit_q <= c_hit;
            state <= S_RESP;
          end else begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (c_done) begin
            hit_q <= c_hit;
            state <= S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            hit_q <= 1'b0;
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset zeroes them at once.
  always_comb begin
    c_valid   = ((state == S_ISSUE) || (state == S_WAIT)) && legal_q;
    c_cmd     = c_valid ? cmd_q  : '0;
    c_addr    = c_valid ? addr_q : '0;
    c_src     = c_valid ? src_q  : '0;
    l1d_gnt   = (state == S_ISSUE) && (src_q == SRC_L1D);
    l1i_gnt   = (state == S_ISSUE) && (src_q == SRC_L1I);
    snp_gnt   = (state == S_ISSUE) && (src_q == SRC_SNP);
    rsp_valid = (state == S_RESP);
    rsp_src   = rsp_valid ? src_q : '0;
    rsp_hit   = rsp_valid & hit_q;
    rsp_err   = rsp_valid & err_q;
    busy      = (state != S_IDLE);
  end

`ifdef L2_ARB_STATS_EN
  logic is_rd;
  logic is_wr;
  assign is_rd = (cmd_q == 4'd0) || (cmd_q == 4'd2);
  assign is_wr = (cmd_q == 4'd1);

  // Count clean completions; a clean clear command wipes all three counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      hit_cnt <= '0;
    end else if (state == S_RESP && !err_q) begin
      if (cmd_q == 4'd8) begin
        rd_cnt  <= '0;
        wr_cnt  <= '0;
        hit_cnt <= '0;
      end else begin
        if (is_rd && rd_cnt != '1) rd_cnt <= rd_cnt + 32'd1;
        if (is_wr && wr_cnt != '1) wr_cnt <= wr_cnt + 32'd1;
        if ((is_rd || is_wr) && hit_q && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter (TIMEOUT=4): directed scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_l2_req_arbiter;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          l1d_req, l1i_req, snp_req;
  logic [3:0]    l1d_cmd, snp_cmd;
  logic [AW-1:0] l1d_addr, l1i_addr, snp_addr;
  logic          l1d_gnt, l1i_gnt, snp_gnt;
  logic          c_valid, c_done, c_hit;
  logic [3:0]    c_cmd;
  logic [AW-1:0] c_addr;
  logic [1:0]    c_src;
  logic          rsp_valid, rsp_hit, rsp_err, busy;
  logic [1:0]    rsp_src;
`ifdef L2_ARB_STATS_EN
  logic [31:0]   rd_cnt, wr_cnt, hit_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l2_req_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .l1d_req(l1d_req), .l1d_cmd(l1d_cmd), .l1d_addr(l1d_addr), .l1d_gnt(l1d_gnt),
    .l1i_req(l1i_req), .l1i_addr(l1i_addr), .l1i_gnt(l1i_gnt),
    .snp_req(snp_req), .snp_cmd(snp_cmd), .snp_addr(snp_addr), .snp_gnt(snp_gnt),
    .c_valid(c_valid), .c_cmd(c_cmd), .c_addr(c_addr), .c_src(c_src),
    .c_done(c_done), .c_hit(c_hit),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .busy(busy)
`ifdef L2_ARB_STATS_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .hit_cnt(hit_cnt)
`endif
  );

  function automatic logic [AW+18:0] all_outs();
    return {l1d_gnt, l1i_gnt, snp_gnt, c_valid, c_cmd, c_addr, c_src,
            rsp_valid, rsp_src, rsp_hit, rsp_err, busy};
  endfunction

  // Drives the cache side for one transaction and records what the DUT did.
  // The datapath asserts c_done on the done_k-th c_valid cycle (0 = first).
  task automatic run_one(input int done_k, input logic hit,
                         output logic [2:0] gmask, output int glat, output int gcyc,
                         output int vcnt, output logic [3:0] ccmd,
                         output logic [AW-1:0] caddr, output logic [1:0] csrc,
                         output bit cstable, output int rcnt,
                         output logic [3:0] rsp, output logic busy_end,
                         output bit tout);
    bit seen = 0;
    int cyc = 0;
    gmask = 0; glat = 0; gcyc = 0; vcnt = 0; ccmd = 0; caddr = 0; csrc = 0;
    cstable = 1; rcnt = 0; rsp = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if ({snp_gnt, l1i_gnt, l1d_gnt} != 3'b000) begin
        if (gcyc == 0) glat = cyc;
        gcyc++;
        gmask |= {snp_gnt, l1i_gnt, l1d_gnt};
        if (l1d_gnt) l1d_req = 0;
        if (l1i_gnt) l1i_req = 0;
        if (snp_gnt) snp_req = 0;
      end
      if (c_valid) begin
        if (vcnt == 0) begin
          ccmd = c_cmd; caddr = c_addr; csrc = c_src;
        end else if (c_cmd !== ccmd || c_addr !== caddr || c_src !== csrc) begin
          cstable = 0;
        end
        c_done = (vcnt == done_k);
        c_hit  = (vcnt == done_k) ? hit : 1'($urandom);
        vcnt++;
      end else begin
        // Noise on the done strobe while nothing is issued must be ignored.
        c_done = 1'($urandom);
        c_hit  = 1'($urandom);
      end
      if (rsp_valid) begin
        seen = 1;
        rcnt++;
        rsp = {rsp_valid, rsp_src, rsp_hit} ^ 4'b0 ;
        rsp = {rsp_src, rsp_hit, rsp_err};
      end
    end
    tout = !seen;
    @(negedge clk);
    c_done = 0;
    if (rsp_valid) rcnt++;
    busy_end = busy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    l1d_req = 0; l1i_req = 0; snp_req = 0; c_done = 0; c_hit = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    l1d_req = 1; l1i_req = 1; snp_req = 1;
    l1d_cmd = 0; snp_cmd = 4; l1d_addr = 1; l1i_addr = 2; snp_addr = 3;
    c_done = 1; c_hit = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h want 0", all_outs());
    end
`ifdef L2_ARB_STATS_EN
    checks++;
    if ({rd_cnt, wr_cnt, hit_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_stats: got %0h want 0", {rd_cnt, wr_cnt, hit_cnt});
    end
`endif
    l1d_req = 0; l1i_req = 0; snp_req = 0; c_done = 0; c_hit = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy got %0b want 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [2:0] gm; int gl, gc, vc, rc; logic [3:0] cc, rs; logic [AW-1:0] ca;
    logic [1:0] cs; bit st, to; logic be;
    l1d_req = 1; l1d_cmd = 0; l1d_addr = 32'h0000_1040;
    run_one(1, 1, gm, gl, gc, vc, cc, ca, cs, st, rc, rs, be, to);
    checks++;
    if ({to, gm, gl[3:0], gc[3:0]} !== {1'b0, 3'b001, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL basic_grant: got to=%0b gnt=%b lat=%0d cyc=%0d want 0 001 1 1", to, gm, gl, gc);
    end
    checks++;
    if ({vc[3:0], cc, ca, cs, st} !== {4'd2, 4'd0, 32'h0000_1040, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL basic_issue: got vcnt=%0d cmd=%0h addr=%0h src=%0d stable=%0b want 2 0 1040 0 1", vc, cc, ca, cs, st);
    end
    checks++;
    if ({rc[3:0], rs, be} !== {4'd1, 2'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_rsp: got n=%0d src/hit/err=%b busy=%0b want 1 0010 0", rc, rs, be);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] gm; int gl, gc, vc, rc; logic [3:0] cc, rs; logic [AW-1:0] ca;
    logic [1:0] cs; bit st, to; logic be;
    logic [2:0] want_g[3] = '{3'b100, 3'b001, 3'b010};
    logic [3:0] want_c[3] = '{4'd4, 4'd0, 4'd2};
    do_reset();
    l1d_req = 1; l1d_cmd = 0; l1d_addr = 32'h100;
    l1i_req = 1; l1i_addr = 32'h200;
    snp_req = 1; snp_cmd = 4; snp_addr = 32'h300;
    for (int k = 0; k < 3; k++) begin
      run_one(0, 1'(k), gm, gl, gc, vc, cc, ca, cs, st, rc, rs, be, to);
      checks++;
      if ({to, gm, gl[3:0], vc[3:0], cc} !== {1'b0, want_g[k], 4'd1, 4'd1, want_c[k]}) begin
        errors++;
        $display("FAIL priority_order[%0d]: got to=%0b gnt=%b lat=%0d vcnt=%0d cmd=%0d want 0 %b 1 1 %0d",
                 k, to, gm, gl, vc, cc, want_g[k], want_c[k]);
      end
      checks++;
      if ({rs[0], rs[1]} !== {1'b0, 1'(k)}) begin
        errors++;
        $display("FAIL priority_rsp[%0d]: got err=%0b hit=%0b want 0 %0d", k, rs[0], rs[1], k % 2);
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] gm; int gl, gc, vc, rc; logic [3:0] cc, rs; logic [AW-1:0] ca;
    logic [1:0] cs; bit st, to; logic be;
    l1d_req = 1; l1d_cmd = 7; l1d_addr = 32'hdead;
    run_one(0, 1, gm, gl, gc, vc, cc, ca, cs, st, rc, rs, be, to);
    checks++;
    if ({to, gm, vc[3:0], rc[3:0], rs} !== {1'b0, 3'b001, 4'd0, 4'd1, 2'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL illegal_cmd: got to=%0b gnt=%b vcnt=%0d n=%0d rsp=%b want 0 001 0 1 0001", to, gm, vc, rc, rs);
    end
    snp_req = 1; snp_cmd = 2; snp_addr = 32'hbeef;
    run_one(0, 1, gm, gl, gc, vc, cc, ca, cs, st, rc, rs, be, to);
    checks++;
    if ({to, gm, vc[3:0], rs} !== {1'b0, 3'b100, 4'd0, 2'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL illegal_snoop: got to=%0b gnt=%b vcnt=%0d rsp=%b want 0 100 0 1001", to, gm, vc, rs);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] gm; int gl, gc, vc, rc; logic [3:0] cc, rs; logic [AW-1:0] ca;
    logic [1:0] cs; bit st, to; logic be;
    l1i_req = 1; l1i_addr = 32'h4000;
    run_one(99, 1, gm, gl, gc, vc, cc, ca, cs, st, rc, rs, be, to);
    checks++;
    if ({to, vc[3:0], rs} !== {1'b0, 4'(TO + 1), 2'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_abort: got to=%0b vcnt=%0d rsp=%b want 0 %0d 0101", to, vc, rs, TO + 1);
    end
    // Done arriving on the very last WAIT cycle still completes cleanly.
    l1i_req = 1;
    run_one(TO, 1, gm, gl, gc, vc, cc, ca, cs, st, rc, rs, be, to);
    checks++;
    if ({to, vc[3:0], rs} !== {1'b0, 4'(TO + 1), 2'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL timeout_edge: got to=%0b vcnt=%0d rsp=%b want 0 %0d 0110", to, vc, rs, TO + 1);
    end
  endtask

  task automatic test_done_idle();
    bit bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      c_done = 1; c_hit = 1'($urandom);
      if (busy || rsp_valid || c_valid) bad = 1;
    end
    @(negedge clk);
    c_done = 0;
    if (busy || rsp_valid || c_valid) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL done_while_idle: got activity=1 want 0");
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] gm; int gl, gc, vc, rc; logic [3:0] cc, rs; logic [AW-1:0] ca;
    logic [1:0] cs; bit st, to; logic be;
    bit stray = 0;
    l1d_req = 1; l1d_cmd = 1; l1d_addr = 32'h55;
    @(negedge clk);
    l1d_req = 0;
    @(negedge clk);
    checks++;
    if ({c_valid, busy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_setup: got valid/busy=%b want 11", {c_valid, busy});
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %0h want 0", all_outs());
    end
    @(negedge clk);
    rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || c_valid || busy) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL reset_mid_silent: got stray activity=1 want 0");
    end
    l1i_req = 1; l1i_addr = 32'h77;
    run_one(0, 0, gm, gl, gc, vc, cc, ca, cs, st, rc, rs, be, to);
    checks++;
    if ({to, gm, gl[3:0], rs} !== {1'b0, 3'b010, 4'd1, 2'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_recover: got to=%0b gnt=%b lat=%0d rsp=%b want 0 010 1 0100", to, gm, gl, rs);
    end
  endtask

`ifdef L2_ARB_STATS_EN
  task automatic test_stats();
    logic [2:0] gm; int gl, gc, vc, rc; logic [3:0] cc, rs; logic [AW-1:0] ca;
    logic [1:0] cs; bit st, to; logic be;
    logic [3:0] cmds[5] = '{4'd0, 4'd2, 4'd0, 4'd1, 4'd8};
    logic       hits[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        checks++;
        if ({rd_cnt, wr_cnt, hit_cnt} !== {32'd3, 32'd1, 32'd2}) begin
          errors++;
          $display("FAIL stats_counts: got rd=%0d wr=%0d hit=%0d want 3 1 2", rd_cnt, wr_cnt, hit_cnt);
        end
      end
      if (cmds[k] == 4'd2) begin
        l1i_req = 1; l1i_addr = 32'(k);
      end else begin
        l1d_req = 1; l1d_cmd = cmds[k]; l1d_addr = 32'(k);
      end
      run_one(1, hits[k], gm, gl, gc, vc, cc, ca, cs, st, rc, rs, be, to);
    end
    checks++;
    if ({rd_cnt, wr_cnt, hit_cnt} !== '0) begin
      errors++;
      $display("FAIL stats_clear: got rd=%0d wr=%0d hit=%0d want 0 0 0", rd_cnt, wr_cnt, hit_cnt);
    end
  endtask
`endif

  function automatic logic [3:0] rnd_l1d();
    if ($urandom_range(0, 3) == 0) return 4'($urandom);
    case ($urandom_range(0, 3))
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [3:0] rnd_snp();
    if ($urandom_range(0, 3) == 0) return 4'($urandom);
    return 4'($urandom_range(3, 6));
  endfunction

  // Reference: snoop first; of the two L1 ports the one not served last wins.
  task automatic test_random();
    logic [2:0] gm; int gl, gc, vc, rc; logic [3:0] cc, rs; logic [AW-1:0] ca;
    logic [1:0] cs; bit st, to; logic be;
    int last_l1 = 1;           // 1 = L1I served last, so L1D is favoured
    int w, dk;
    logic h, legal, e_err, e_hit;
    logic [3:0] e_cmd;
    logic [AW-1:0] e_addr;
    int e_vc;
    int m_rd = 0, m_wr = 0, m_hit = 0;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if (!l1d_req && $urandom_range(0, 1) == 1) begin
        l1d_req = 1; l1d_cmd = rnd_l1d(); l1d_addr = $urandom;
      end
      if (!l1i_req && $urandom_range(0, 1) == 1) begin
        l1i_req = 1; l1i_addr = $urandom;
      end
      if (!snp_req && $urandom_range(0, 2) == 0) begin
        snp_req = 1; snp_cmd = rnd_snp(); snp_addr = $urandom;
      end
      if (!l1d_req && !l1i_req && !snp_req) begin
        l1i_req = 1; l1i_addr = $urandom;
      end
      if (snp_req) w = 2;
      else if (l1d_req && l1i_req) w = (last_l1 == 1) ? 0 : 1;
      else w = l1d_req ? 0 : 1;
      if (w != 2) last_l1 = w;
      e_cmd  = (w == 2) ? snp_cmd : (w == 1) ? 4'd2 : l1d_cmd;
      e_addr = (w == 2) ? snp_addr : (w == 1) ? l1i_addr : l1d_addr;
      legal  = (w == 1) || (w == 2 && e_cmd >= 3 && e_cmd <= 6) ||
               (w == 0 && (e_cmd == 0 || e_cmd == 1 || e_cmd == 8 || e_cmd == 9));
      dk = $urandom_range(0, 6);
      h  = 1'($urandom);
      e_vc  = !legal ? 0 : (dk <= TO) ? dk + 1 : TO + 1;
      e_err = !legal || dk > TO;
      e_hit = !e_err && h;
      run_one(dk, h, gm, gl, gc, vc, cc, ca, cs, st, rc, rs, be, to);
      checks++;
      if ({to, gm, gl[3:0], gc[3:0], vc[3:0]} !== {1'b0, 3'(1 << w), 4'd1, 4'd1, 4'(e_vc)}) begin
        errors++;
        $display("FAIL rand_flow[%0d]: got to=%0b gnt=%b lat=%0d gcyc=%0d vcnt=%0d want 0 %b 1 1 %0d",
                 n, to, gm, gl, gc, vc, 3'(1 << w), e_vc);
      end
      if (e_vc > 0) begin
        checks++;
        if ({cc, ca, cs, st} !== {e_cmd, e_addr, 2'(w), 1'b1}) begin
          errors++;
          $display("FAIL rand_issue[%0d]: got cmd=%0h addr=%0h src=%0d stable=%0b want %0h %0h %0d 1",
                   n, cc, ca, cs, st, e_cmd, e_addr, w);
        end
      end
      checks++;
      if ({rc[3:0], rs, be} !== {4'd1, 2'(w), e_hit, e_err, 1'b0}) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: got n=%0d src/hit/err=%b busy=%0b want 1 %b 0",
                 n, rc, rs, be, {2'(w), e_hit, e_err});
      end
      if (!e_err && e_cmd == 4'd8) begin
        m_rd = 0; m_wr = 0; m_hit = 0;
      end else if (!e_err) begin
        if (e_cmd == 4'd0 || e_cmd == 4'd2) m_rd++;
        if (e_cmd == 4'd1) m_wr++;
        if (e_cmd <= 4'd2 && e_hit) m_hit++;
      end
`ifdef L2_ARB_STATS_EN
      checks++;
      if ({rd_cnt, wr_cnt, hit_cnt} !== {32'(m_rd), 32'(m_wr), 32'(m_hit)}) begin
        errors++;
        $display("FAIL rand_stats[%0d]: got %0d %0d %0d want %0d %0d %0d",
                 n, rd_cnt, wr_cnt, hit_cnt, m_rd, m_wr, m_hit);
      end
`endif
    end
    l1d_req = 0; l1i_req = 0; snp_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_done_idle();
    test_reset_mid();
`ifdef L2_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
